// File: rtl/bit_shift_arb_pkg.sv
// rtl/bit_shift_arb_pkg.sv - shared widths and FSM state encoding for bit_shift_arbiter
package bit_shift_arb_pkg;

    localparam int DATA_IN_W  = 16;
    localparam int DATA_OUT_W = 8;
    localparam int SHAMT_W    = 3;
    localparam int STAT_W     = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        RESP  = 2'd2
    } state_e;

endpackage

// File: rtl/bit_shift_arbiter_rr_arbiter.sv
// rtl/bit_shift_arbiter_rr_arbiter.sv - combinational round-robin grant picker (pointer held by parent)
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic          advance,
    input  logic [IW-1:0] last_grant,
    output logic [N-1:0]  grant
);

    logic found;

    // Search upward from the slot after last_grant, wrapping at N; first requester found wins.
    always_comb begin
        grant = '0;
        found = 1'b0;
        if (advance) begin
            for (int k = 1; k <= N; k++) begin
                for (int i = 0; i < N; i++) begin
                    if (!found && req[i] && (i == ((int'(last_grant) + k) % N))) begin
                        grant[i] = 1'b1;
                        found    = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/bit_shift_arbiter.sv
// rtl/bit_shift_arbiter.sv - round-robin sharing of one bit_shift unit; optional BIT_SHIFT_ARB_STATS_EN grant counters
module bit_shift_arbiter #(
    parameter  int NUM_REQ    = 4,
    parameter  int DATA_IN_W  = bit_shift_arb_pkg::DATA_IN_W,
    parameter  int DATA_OUT_W = bit_shift_arb_pkg::DATA_OUT_W,
    parameter  int SHAMT_W    = bit_shift_arb_pkg::SHAMT_W,
    localparam int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*DATA_IN_W-1:0]   req_data,
    input  logic [NUM_REQ*SHAMT_W-1:0]     req_shamt,
    input  logic [NUM_REQ-1:0]             req_dir,
    output logic [DATA_IN_W-1:0]           sh_data_in,
    output logic [SHAMT_W-1:0]             sh_shift_amount,
    output logic                           sh_shift_direction,
    input  logic [DATA_OUT_W-1:0]          sh_data_out,
    output logic                           resp_valid,
    input  logic                           resp_ready,
    output logic [DATA_OUT_W-1:0]          resp_data,
    output logic [ID_W-1:0]                resp_id
`ifdef BIT_SHIFT_ARB_STATS_EN
    ,
    output logic [NUM_REQ*bit_shift_arb_pkg::STAT_W-1:0] grant_count
`endif
);

    import bit_shift_arb_pkg::*;

    state_e                 state_q;
    logic [ID_W-1:0]        last_grant_q;
    logic [ID_W-1:0]        id_q;
    logic [DATA_IN_W-1:0]   sh_data_q;
    logic [SHAMT_W-1:0]     sh_shamt_q;
    logic                   sh_dir_q;
    logic                   resp_valid_q;
    logic [DATA_OUT_W-1:0]  resp_data_q;
    logic [ID_W-1:0]        resp_id_q;

    logic [NUM_REQ-1:0]     grant;
    logic [ID_W-1:0]        grant_idx;
    logic [DATA_IN_W-1:0]   sel_data;
    logic [SHAMT_W-1:0]     sel_shamt;
    logic                   sel_dir;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req        (req_valid),
        .advance    ((state_q == IDLE) && !reset),
        .last_grant (last_grant_q),
        .grant      (grant)
    );

    // One-hot grant to index and operand mux for the granted requester.
    always_comb begin
        grant_idx = '0;
        sel_data  = '0;
        sel_shamt = '0;
        sel_dir   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                grant_idx = ID_W'(i);
                sel_data  = req_data[i*DATA_IN_W +: DATA_IN_W];
                sel_shamt = req_shamt[i*SHAMT_W +: SHAMT_W];
                sel_dir   = req_dir[i];
            end
        end
    end

    // Accept in IDLE, let the shifter settle in SHIFT, hold the response in RESP until taken.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= ID_W'(NUM_REQ - 1);
            id_q         <= '0;
            sh_data_q    <= '0;
            sh_shamt_q   <= '0;
            sh_dir_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_id_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|req_valid) begin
                        sh_data_q    <= sel_data;
                        sh_shamt_q   <= sel_shamt;
                        sh_dir_q     <= sel_dir;
                        id_q         <= grant_idx;
                        last_grant_q <= grant_idx;
                        state_q      <= SHIFT;
                    end
                end
                SHIFT: begin
                    resp_data_q  <= sh_data_out;
                    resp_id_q    <= id_q;
                    resp_valid_q <= 1'b1;
                    state_q      <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready          = grant;
    assign sh_data_in         = sh_data_q;
    assign sh_shift_amount    = sh_shamt_q;
    assign sh_shift_direction = sh_dir_q;
    assign resp_valid         = resp_valid_q;
    assign resp_data          = resp_data_q;
    assign resp_id            = resp_id_q;

`ifdef BIT_SHIFT_ARB_STATS_EN
    logic [NUM_REQ*STAT_W-1:0] cnt_q;

    // Per-requester accept counters, saturating at all-ones.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_ready[i] && (cnt_q[i*STAT_W +: STAT_W] != {STAT_W{1'b1}})) begin
                    cnt_q[i*STAT_W +: STAT_W] <= cnt_q[i*STAT_W +: STAT_W] + STAT_W'(1);
                end
            end
        end
    end

    assign grant_count = cnt_q;
`endif

endmodule
